// File: rtl/reg_file_mp_pkg.sv
// Shared encodings and helpers for the multi-port integer register file.
// Clear-sweep state encodings match the core's shared define values.
package reg_file_mp_pkg;

   typedef enum logic {
      RF_ST_IDLE  = 1'b0,
      RF_ST_CLEAR = 1'b1
   } rf_state_e;

   localparam int unsigned RF_ZERO_IDX = 0;

   // True for an architectural register that actually holds data (not x0, not past the top).
   function automatic logic addr_ok(input logic [31:0] a, input int unsigned nregs);
      return (a != 32'(RF_ZERO_IDX)) && (a < nregs);
   endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear sequencer: walks entries 1..NREGS-1, one per clock, after reset or a clear request.
// busy is the state flop itself, so it is a registered output.
module rf_clear_fsm
   import reg_file_mp_pkg::*;
#(
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   rf_state_e       state;
   logic [AW-1:0]   ptr;

   // NOTE: state and pointer use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RF_ST_CLEAR;
         ptr   <= AW'(1);
      end else begin
         case (state)
            RF_ST_IDLE: begin
               if (clr) begin
                  state <= RF_ST_CLEAR;
                  ptr   <= AW'(1);
               end
            end
            RF_ST_CLEAR: begin
               if (ptr == LAST) state <= RF_ST_IDLE;
               else             ptr   <= ptr + AW'(1);
            end
            default: state <= RF_ST_CLEAR;
         endcase
      end
   end

   assign busy     = (state == RF_ST_CLEAR);
   // The reset edge itself only restarts the sweep; storage is left alone.
   assign clr_en   = busy & ~rst;
   assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised NRD-read / 1-write integer register file with x0 hardwired to zero,
// optional write-to-read bypass, and a sequential clear sweep that stalls via busy.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [XLEN-1:0]     wd,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic                busy
);

   logic [XLEN-1:0] mem [NREGS];
   logic            clr_en;
   logic [AW-1:0]   clr_addr;
   logic            wr_req;
   logic            wr_en;

   rf_clear_fsm #(.NREGS(NREGS)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (busy),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // wr_req qualifies bypass; the reset edge additionally drops the actual store.
   assign wr_req = we & ~busy & ~clr & addr_ok(32'(wa), NREGS);
   assign wr_en  = wr_req & ~rst;

   // NOTE: storage has no reset; the clear sweep zeroes it and busy masks reads until then.
   always_ff @(posedge clk) begin
      if (clr_en)     mem[clr_addr] <= '0;
      else if (wr_en) mem[wa]       <= wd;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] q;

      assign a = ra[i*AW +: AW];

      // NOTE: every branch assigns q, so this stays purely combinational.
      always_comb begin
         if (busy || !addr_ok(32'(a), NREGS))       q = '0;
         else if ((BYPASS != 0) && wr_req && wa == a) q = wd;
         else                                          q = mem[a];
      end

      assign rd[i*XLEN +: XLEN] = q;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations share one stimulus stream and are
// checked every cycle against an abstract register-file model plus literal expectations.
module tb_reg_file_mp;

   localparam int NI = 3;
   localparam int NREGS_C [NI] = '{32, 24, 32};
   localparam int NRD_C   [NI] = '{3, 2, 1};
   localparam int BYP_C   [NI] = '{1, 1, 0};

   // ABI names of the registers used below
   localparam logic [4:0] ZERO = 5'd0, GP = 5'd3, T0 = 5'd5, T2 = 5'd7,
                          S1 = 5'd9, T5 = 5'd30, T6 = 5'd31;

   logic        clk = 1'b0;
   logic        rst, clr, we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra_v [3];
   logic [95:0] rd_a;
   logic [63:0] rd_b;
   logic [31:0] rd_c;
   logic        busy_a, busy_b, busy_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra({ra_v[2], ra_v[1], ra_v[0]}), .rd(rd_a), .busy(busy_a));

   reg_file_mp #(.XLEN(32), .NREGS(24), .NRD(2), .BYPASS(1)) u_dut24 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra({ra_v[1], ra_v[0]}), .rd(rd_b), .busy(busy_b));

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(1), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra(ra_v[0]), .rd(rd_c), .busy(busy_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Abstract model: per instance, the register contents and the edges left in a clear.
   logic [31:0] mdl_mem [NI][64];
   int          mdl_rem [NI] = '{0, 0, 0};
   bit          started = 1'b0;

   function automatic bit wr_valid(int k);
      return we && !clr && wa != 0 && int'(wa) < NREGS_C[k];
   endfunction

   always @(posedge clk) begin
      if (rst) started = 1'b1;
      for (int k = 0; k < NI; k++) begin
         if (rst) mdl_rem[k] = NREGS_C[k] - 1;
         else if (mdl_rem[k] > 0) begin
            mdl_rem[k]--;
            if (mdl_rem[k] == 0)
               for (int e = 0; e < 64; e++) mdl_mem[k][e] = '0;
         end else if (clr) mdl_rem[k] = NREGS_C[k] - 1;
         else if (wr_valid(k)) mdl_mem[k][wa] = wd;
      end
   end

   function automatic logic [31:0] exp_rd(int k, int p);
      logic [4:0] a = ra_v[p];
      if (mdl_rem[k] > 0) return '0;
      if (a == 0 || int'(a) >= NREGS_C[k]) return '0;
      if (BYP_C[k] != 0 && wr_valid(k) && wa == a) return wd;
      return mdl_mem[k][a];
   endfunction

   function automatic logic [31:0] get_rd(int k, int p);
      case (k)
         0:       return rd_a[p*32 +: 32];
         1:       return rd_b[p*32 +: 32];
         default: return rd_c;
      endcase
   endfunction

   function automatic logic get_busy(int k);
      case (k)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d.busy", k), 32'(get_busy(k)), 32'(mdl_rem[k] > 0));
            for (int p = 0; p < NRD_C[k]; p++)
               check($sformatf("i%0d.rd%0d", k, p), get_rd(k, p), exp_rd(k, p));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
      tick();
      we = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_a !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
   endtask

   int n;

   initial begin
      rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0;
      ra_v = '{default: '0};

      // 1: reset sweep
      tick();
      check("busy_after_rst", 32'(busy_a), 32'd1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rd0_during_sweep", rd_a[31:0], 32'd0);
      wait_idle(n);
      check("rst_sweep_edges", 32'(n), 32'd31);

      // 2: write/read across ports, then fill the file with distinct patterns
      write(T0, 32'hDEAD_BEEF);
      write(T6, 32'h1234_5678);
      ra_v = '{T0, T6, T6};
      @(negedge clk);
      check("x5_port0", rd_a[31:0], 32'hDEAD_BEEF);
      check("x31_port1", rd_a[63:32], 32'h1234_5678);
      check("x31_port2", rd_a[95:64], 32'h1234_5678);
      check("nb_x5", rd_c, 32'hDEAD_BEEF);
      ra_v[0] = T5;
      @(negedge clk);
      check("x30_zero", rd_a[31:0], 32'd0);
      for (int r = 1; r < 31; r++) write(5'(r), 32'hA5A5_0000 ^ (32'(r) * 32'h0001_0203));
      for (int r = 0; r < 32; r += 3) begin
         ra_v = '{5'(r), 5'(r + 1), 5'(r + 2)};
         tick();
      end

      // 3: zero register and out-of-range writes
      write(ZERO, 32'hFFFF_FFFF);
      ra_v = '{ZERO, ZERO, ZERO};
      @(negedge clk);
      check("x0_zero", rd_a[31:0], 32'd0);
      write(5'd25, 32'hCAFE_F00D);
      ra_v = '{5'd25, 5'd25, 5'd25};
      @(negedge clk);
      check("n24_ra25_zero", rd_b[31:0], 32'd0);
      check("n32_x25", rd_a[31:0], 32'hCAFE_F00D);
      for (int r = 0; r < 32; r += 2) begin
         ra_v = '{5'(r), 5'(r + 1), 5'(r)};
         tick();
      end

      // 4: bypass vs no bypass
      write(T2, 32'h11);
      ra_v = '{T2, T2, T2};
      we = 1'b1; wa = T2; wd = 32'h22;
      @(negedge clk);
      check("byp_rd0", rd_a[31:0], 32'h22);
      check("nobyp_rd0_old", rd_c, 32'h11);
      tick();
      we = 1'b0;
      @(negedge clk);
      check("nobyp_rd0_new", rd_c, 32'h22);

      // 5: clear vs write collision, clr and write during sweep ignored
      write(GP, 32'h33);
      clr = 1'b1; we = 1'b1; wa = GP; wd = 32'hAA;
      tick();
      clr = 1'b0; we = 1'b0;
      check("busy_after_clr", 32'(busy_a), 32'd1);
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      write(S1, 32'h99);
      wait_idle(n);
      check("clr_sweep_edges", 32'(n + 5), 32'd31);
      ra_v = '{GP, S1, ZERO};
      @(negedge clk);
      check("x3_cleared", rd_a[31:0], 32'd0);
      check("x9_dropped", rd_a[63:32], 32'd0);

      // 6: reset mid-sweep restarts the sweep
      for (int r = 1; r < 32; r += 5) write(5'(r), 32'h5000_0000 + 32'(r));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("busy_mid_rst", 32'(busy_a), 32'd1);
      wait_idle(n);
      check("restart_sweep_edges", 32'(n), 32'd31);
      for (int r = 1; r < 32; r += 3) begin
         ra_v = '{5'(r), 5'(r + 1), 5'(r + 2)};
         tick();
      end
      ra_v[0] = T6;
      @(negedge clk);
      check("x31_after_restart", rd_a[31:0], 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file, successor to the fixed 2R1W, 32x32 file in the core datapath.
- Width, depth and read-port count are configurable.
- Read ports are combinational, with optional write-to-read bypass.
- Clearing is sequential, one entry per cycle, and is started by reset or by a software/debug clear request. A busy flag stalls the pipeline while clearing is in progress.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; entry 0 is hardwired to zero; legal range 2..64.
- NRD, 2, number of read ports; legal range 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored contents only.
- AW (localparam), clog2(NREGS), address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  request a full clear sweep (single-cycle pulse or level)
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- ra  in  NRD*AW  packed read addresses; port i = ra[i*AW +: AW]
- rd  out  NRD*XLEN  packed read data; port i = rd[i*XLEN +: XLEN]
- busy  out  1  clear sweep in progress; registered

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- State machine has two states: IDLE and CLEAR. A sweep pointer ptr is AW bits wide.
- Clock edge with rst=1: state<=CLEAR, ptr<=1. Storage is not touched on this edge. Holding rst high holds ptr at 1.
- Clock edge in CLEAR with rst=0:
  - mem[ptr]<=0.
  - If ptr==NREGS-1: state<=IDLE. Otherwise ptr<=ptr+1.
  - The sweep therefore takes NREGS-1 edges after rst falls.
- Clock edge in IDLE with clr=1: state<=CLEAR, ptr<=1. Any write on that edge is dropped (clr wins).
- clr while in CLEAR is ignored; it does not restart the sweep.
- busy = (state==CLEAR). It is 1 from the first edge with rst=1 until the final sweep edge.
  - Reset value of busy: 1.
  - Reset value of rd: all zeros.
- Writes:
  - A write occurs on the edge only when we=1, busy=0, no clr, wa!=0 and wa<NREGS.
  - Writes with busy=1, to wa==0, or to wa>=NREGS are silently dropped.
- Reads, port i, combinational, in priority order:
  - busy=1 -> 0.
  - ra_i==0 or ra_i>=NREGS -> 0.
  - BYPASS=1 and the current cycle's write is valid by the rule above (we=1, busy=0, clr=0, wa!=0, wa<NREGS) and wa==ra_i -> wd.
  - Otherwise -> mem[ra_i].
  - All ports are independent. Any number of ports may address the same register in one cycle and all return the same value.
- Every entry 1..NREGS-1 maps one-to-one to its own index; there is no address aliasing or permutation. In particular, x30 reads x30 and x31 reads x31.
- Storage contents after power-up are don't-care. Reads gated by busy are defined, so no X reaches rd once rst has been applied.
- Reset mid-sweep restarts the sweep at ptr=1.
- Reset or clr during a write: the write is dropped.

Decomposition:
- Shared defines file `risc-v-defines.v` gains:
  - state encodings RF_ST_IDLE=1'b0, RF_ST_CLEAR=1'b1;
  - RF_ZERO_IDX=0.
  - The existing ABI register index names are reused in benches.
- One sub-module, rf_clear_fsm. It holds the state, ptr and busy, and outputs clr_en plus clr_addr to the storage array.
- The read-port mux and bypass logic are a generate loop over NRD inside reg_file_mp.

Test Plan:
1. Reset sweep: rst=1 for 2 cycles, then 0 (NREGS=32) -> busy=1 immediately, stays 1 for exactly 31 edges after rst falls, then 0; all rd=0 throughout.
2. Write/read, all ports: write 0xDEADBEEF to x5 and 0x12345678 to x31, then ra0=5, ra1=31, ra2=31 (NRD=3) -> rd0=0xDEADBEEF, rd1=rd2=0x12345678. Also read x30 -> 0.
3. Zero register and out of range: write 0xFFFFFFFF to wa=0, then read x0 -> 0. With NREGS=24, write to wa=25 and read ra=25 -> 0, and no entry changes.
4. Bypass:
   - BYPASS=1: x7 holds 0x11, same-cycle we=1, wa=7, wd=0x22, ra0=7 -> rd0=0x22 combinationally.
   - BYPASS=0: same stimulus -> rd0=0x11, then 0x22 on the next cycle.
5. Clear vs write collision: in IDLE, clr=1 and we=1, wa=3, wd=0xAA on the same edge -> busy=1 next cycle; after the sweep, x3 reads 0. A write attempted mid-sweep is also dropped.
6. Reset mid-sweep: clr, 10 sweep edges, then rst=1 for 1 cycle -> busy stays 1 and the sweep restarts (31 more edges); x1..x31 all read 0 afterwards.
